imem_loader: RTL

Boot-time instruction loader for the single-cycle MIPS core: the producer side of the opcode interface that the main control decoder consumes. It accepts symbolic instructions (class plus fields) over a valid/ready stream and encodes each into a 32-bit MIPS word using the decoder's opcode constants. It writes the words sequentially into instruction memory and holds the CPU until the program is complete. It sits between the test/host stimulus port and the instruction-memory write port.

---
 rtl/imem_loader_pkg.sv | 40 ++++
 rtl/imem_loader_instr_encode.sv | 33 +++
 rtl/imem_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared control-encoding definitions: MIPS opcodes used by the main control
// decoder, the loader's instruction-class codes, error codes and FSM states.
package imem_loader_pkg;

    // Primary opcode field values (bits 31:26), shared with the control decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Instruction class codes presented on in_kind; 5..7 are illegal
    localparam logic [2:0] KIND_R   = 3'd0;
    localparam logic [2:0] KIND_LW  = 3'd1;
    localparam logic [2:0] KIND_SW  = 3'd2;
    localparam logic [2:0] KIND_BEQ = 3'd3;
    localparam logic [2:0] KIND_J   = 3'd4;

    // Sticky error codes
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    // I-type word: opcode, rs, rt, 16-bit immediate
    function automatic logic [31:0] itype(input logic [5:0]  op,
                                          input logic [4:0]  rs,
                                          input logic [4:0]  rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/imem_loader_instr_encode.sv
// Combinational encoder: symbolic instruction class plus fields to a 32-bit
// MIPS word. Fields not used by a class are ignored; illegal classes raise a
// flag and produce an all-zero word.
module instr_encode
    import imem_loader_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the instruction format from the class code
    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (kind)
            KIND_R:   word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            KIND_LW:  word = itype(OP_LW,  rs, rt, imm);
            KIND_SW:  word = itype(OP_SW,  rs, rt, imm);
            KIND_BEQ: word = itype(OP_BEQ, rs, rt, imm);
            KIND_J:   word = {OP_J, target};
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction loader: accepts symbolic instructions over a
// valid/ready stream, encodes them, writes them sequentially into instruction
// memory and holds the CPU in reset until the whole program is loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              cpu_hold,
    output logic              done,
    output logic [1:0]        err
);

    // Highest word address; reaching it without a last marker is an overflow
    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q,   ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                last_q,  last_d;
    logic [1:0]          err_q,   err_d;

    logic [31:0]         enc_word;
    logic                enc_illegal;

    instr_encode u_encode (
        .kind    (in_kind),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .funct   (in_funct),
        .imm     (in_imm),
        .target  (in_target),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // Next-state logic: latch on handshake, commit the write, decide the exit
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    if (enc_illegal) begin
                        state_d = ST_FAULT;
                        err_d   = ERR_ILLEGAL;
                    end else begin
                        state_d = ST_WRITE;
                        addr_d  = ptr_q;
                        wdata_d = enc_word;
                        last_d  = in_last;
                    end
                end
            end
            ST_WRITE: begin
                count_d = count_q + 1'b1;
                // The pointer stops at the top address instead of wrapping
                if (ptr_q != PTR_MAX) begin
                    ptr_d = ptr_q + 1'b1;
                end
                if (last_q) begin
                    state_d = ST_DONE;
                end else if (ptr_q == PTR_MAX) begin
                    state_d = ST_FAULT;
                    err_d   = ERR_OVERFLOW;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            ptr_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from state; rst forces the reset values in the same cycle
    always_comb begin
        in_ready   = !rst && (state_q == ST_LOAD);
        imem_we    = !rst && (state_q == ST_WRITE);
        imem_addr  = rst ? '0    : addr_q;
        imem_wdata = rst ? 32'h0 : wdata_q;
        count      = rst ? '0    : count_q;
        done       = !rst && (state_q == ST_DONE);
        cpu_hold   = !done;
        err        = rst ? ERR_NONE : err_q;
    end

endmodule
